// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_arb_resp_buf.sv
// Holds one paired read result until the decode stage consumes it.
module regfile_arb_resp_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            resp_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rs1v,
  output logic [XLEN-1:0] resp_rs2v
);

  // Capture on request, drop valid on consume; data stays put until recaptured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rs1v  <= '0;
      resp_rs2v  <= '0;
    end else if (capture) begin
      resp_valid <= 1'b1;
      resp_rs1v  <= rs1_in;
      resp_rs2v  <= rs2_in;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single register-file port between paired reads and writebacks.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned MAX_WB_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [REG_AW-1:0] rd_req_rs1,
  input  logic [REG_AW-1:0] rd_req_rs2,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [XLEN-1:0]   rd_resp_rs1v,
  output logic [XLEN-1:0]   rd_resp_rs2v,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              rf_clr,
  output logic              rf_write,
  output logic [REG_AW-1:0] rf_rd,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  output logic [XLEN-1:0]   rf_din,
  input  logic [XLEN-1:0]   rf_rs1_out,
  input  logic [XLEN-1:0]   rf_rs2_out
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WB_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q;
  wb_req_t             wb_req;
  logic                wb_real;
  logic                rd_wins;
  logic                rd_gnt;
  logic                wr_gnt;

  assign wb_req = '{rd: wb_rd, data: wb_data};

  // State register; reset re-enters the clear cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Arbitration, next state and register-file command lines.
  always_comb begin
    state_d      = state_q;
    rd_gnt       = 1'b0;
    wr_gnt       = 1'b0;
    rd_req_ready = 1'b0;
    wb_ready     = 1'b0;
    rf_clr       = 1'b0;
    rf_write     = 1'b0;
    rf_rd        = '0;
    rf_rs1       = '0;
    rf_rs2       = '0;
    rf_din       = '0;
    // x0 writes never use the port, so they cannot block a read
    wb_real      = wb_valid && (wb_req.rd != '0);
    rd_wins      = !wb_real || (streak_q == STREAK_MAX);

    unique case (state_q)
      INIT: begin
        rf_clr  = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        rd_req_ready = rd_wins;
        rd_gnt       = rd_req_valid && rd_wins;
        if (rd_gnt) state_d = RDWAIT;
      end
      RDWAIT: state_d = RESP;
      RESP: begin
        if (rd_resp_ready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase

    if (state_q != INIT) begin
      wr_gnt   = wb_real && !rd_gnt;
      wb_ready = !rd_gnt || (wb_req.rd == '0);
    end

    if (wr_gnt) begin
      rf_write = 1'b1;
      rf_rd    = wb_req.rd;
      rf_din   = wb_req.data;
    end else if (rd_gnt) begin
      rf_rs1 = rd_req_rs1;
      rf_rs2 = rd_req_rs2;
    end
  end

  // Consecutive write wins against a waiting read; bounded to stop starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (!rd_req_valid || rd_gnt) begin
      streak_q <= '0;
    end else if (wr_gnt && (state_q == IDLE) && (streak_q != STREAK_MAX)) begin
      streak_q <= streak_q + STREAK_W'(1);
    end
  end

  regfile_arb_resp_buf #(
    .XLEN (XLEN)
  ) u_resp_buf (
    .clk        (clk),
    .rst        (rst),
    .capture    (state_q == RDWAIT),
    .rs1_in     (rf_rs1_out),
    .rs2_in     (rf_rs2_out),
    .resp_ready (rd_resp_ready),
    .resp_valid (rd_resp_valid),
    .resp_rs1v  (rd_resp_rs1v),
    .resp_rs2v  (rd_resp_rs2v)
  );

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Sequencer that shares the single-ported 32×32 register file between decode-stage read requests (rs1/rs2 pair) and writeback-stage write requests. Each cycle the register file does either one paired read or one write, so this block arbitrates, drives the register-file command lines, and handles the one-cycle read latency. It also captures read results into a held response buffer and runs the post-reset clear. It sits between the decode and writeback stages and the register file.

## Interface
Parameters:
- XLEN, 32, register data width
- REG_AW, 5, register address width
- MAX_WB_STREAK, 4, consecutive write grants allowed while a read is waiting; 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- rd_req_valid  in  1  decode read request
- rd_req_ready  out  1  read request accepted this cycle
- rd_req_rs1, rd_req_rs2  in  REG_AW  source register addresses
- rd_resp_valid  out  1  read response held
- rd_resp_ready  in  1  response consumed
- rd_resp_rs1v, rd_resp_rs2v  out  XLEN  read data
- wb_valid  in  1  writeback request
- wb_ready  out  1  write accepted this cycle
- wb_rd  in  REG_AW  destination register
- wb_data  in  XLEN  write data
- rf_clr  out  1  register-file synchronous clear
- rf_write  out  1  1 = write, 0 = read
- rf_rd, rf_rs1, rf_rs2  out  REG_AW  register-file addresses
- rf_din  out  XLEN  register-file write data
- rf_rs1_out, rf_rs2_out  in  XLEN  register-file registered read data

## Operation
- FSM states:
  - INIT: rf_clr=1; all readys 0. Lasts while rst is high plus exactly one clk after rst falls.
  - IDLE: no read outstanding.
  - RDWAIT: read issued last cycle; register-file outputs are valid this cycle.
  - RESP: rd_resp_valid=1; response held.
- Transitions:
  - INIT→IDLE after the clear cycle.
  - IDLE→RDWAIT on a read grant.
  - RDWAIT→RESP always; rf_rs1_out/rf_rs2_out are captured at the end of RDWAIT.
  - RESP→IDLE on rd_resp_ready.
- Read eligibility: only in IDLE. No second read while in RDWAIT or RESP.
- Writes are eligible in IDLE, RDWAIT and RESP. The response is already captured, or is captured on the same edge that the write lands, so the register file zeroing its outputs on a write is harmless.
- Arbitration when a read is eligible and wb_valid=1: the write wins unless streak==MAX_WB_STREAK, in which case the read wins.
- Streak counter (4 bits):
  - increments on each write grant while rd_req_valid=1 and a read is eligible but not granted;
  - clears on a read grant or whenever rd_req_valid=0;
  - saturates at MAX_WB_STREAK.
- Writes to x0 (wb_rd==0):
  - wb_ready=1 in any non-INIT state;
  - no register-file write, rf_write=0;
  - does not occupy the port, so a read may be granted in the same cycle;
  - does not touch the streak counter.
- Command outputs are combinational from the grant:
  - write grant: rf_write=1, rf_rd=wb_rd, rf_din=wb_data.
  - read grant: rf_write=0, rf_rs1/rf_rs2 = request addresses.
  - no grant: rf_write=0, addresses 0, rf_din 0.
- Ordering: a write granted in cycle N is visible to any read granted in cycle ≥N+1.
- Reset mid-operation: all state drops to reset values, any held response is discarded, and INIT repeats.

## Timing
- Reset values:
  - rd_req_ready=0, wb_ready=0
  - rd_resp_valid=0, rd_resp_rs1v=0, rd_resp_rs2v=0
  - rf_clr=1, rf_write=0, all rf addresses and rf_din=0
  - streak=0, state=INIT
- Read latency: handshake in cycle N → rd_resp_valid=1 from cycle N+2. Data is stable until consumed.
- Read throughput: one read per 3 cycles when rd_resp_ready is held at 1.
- Write latency: handshake in cycle N → register-file contents updated at the end of N.
- rd_req_ready and wb_ready are combinational. A requester must hold valid and payload until ready.

## Structure
- Package regfile_arb_pkg holds XLEN, REG_AW, the state enum (INIT, IDLE, RDWAIT, RESP) and a write-request struct {rd, data}.
- One natural sub-module, regfile_arb_resp_buf: a capture register plus valid/ready hold for the response.
- Arbitration and the FSM stay in the top module.

## Test plan
- Reset release: rst low at cycle 0 → rf_clr=1 for exactly one cycle, then rf_clr=0, readys become eligible, rd_resp_valid=0.
- Write-then-read: write x5=0xDEADBEEF, then read rs1=5, rs2=0 → two cycles after the read handshake, rd_resp_rs1v=0xDEADBEEF and rd_resp_rs2v=0.
- x0 discard: write x0=0x1234 in the same cycle as a read request → both accepted in that cycle, rf_write=0; a later read of x0 returns 0.
- Starvation bound: wb_valid held high with distinct rd, rd_req_valid high, MAX_WB_STREAK=4 → exactly 4 write grants, then a read grant, and the streak counter clears.
- Response backpressure: rd_resp_ready=0 for 10 cycles while writes continue → rd_resp_rs1v/rd_resp_rs2v unchanged, rd_req_ready=0 until consumed; writes are accepted every cycle.
- Mid-op reset: rst asserted in RDWAIT → rd_resp_valid never rises, INIT repeats, and all outputs return to reset values asynchronously.
